ex3_mem_writer: RTL and testbench

- Producer-side counterpart of the EX3 min/sum reader.
- On a one-cycle `go`, accepts DEPTH bytes over a valid/ready stream and writes them into the 32x8 data memory that EX3 later scans.
- Pulses `done` when the memory is filled, so `done` can drive EX3's `go` directly.
- Keeps golden min and sum of the written bytes so the bench can cross-check EX3's `min`/`sum`.

---
 rtl/ex3_pkg.sv | 17 +
 rtl/ex3_stat_acc.sv | 49 ++++
 rtl/ex3_mem_writer.sv | 112 +++++++++++
 tb/tb_ex3_mem_writer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ex3_pkg.sv
// Constants and state encoding shared by the EX3 reader, the memory writer
// and their benches.
package ex3_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int SW    = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/ex3_stat_acc.sv
// Running min/sum accumulator over a byte stream.
// clr_i restarts the statistics; upd_i folds data_i into them.
module ex3_stat_acc
    import ex3_pkg::*;
#(
    parameter int P_DW = DW,
    parameter int P_SW = SW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            upd_i,
    input  logic [P_DW-1:0] data_i,
    output logic [P_DW-1:0] min_o,
    output logic [P_SW-1:0] sum_o
);

    logic [P_DW-1:0] min_q, min_d;
    logic [P_SW-1:0] sum_q, sum_d;

    always_comb begin
        min_d = min_q;
        sum_d = sum_q;
        if (clr_i) begin
            // all-ones so that the first byte always becomes the minimum
            min_d = '1;
            sum_d = '0;
        end else if (upd_i) begin
            sum_d = sum_q + P_SW'(data_i);
            if (data_i < min_q) begin
                min_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_q <= '0;
            sum_q <= '0;
        end else begin
            min_q <= min_d;
            sum_q <= sum_d;
        end
    end

    assign min_o = min_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/ex3_mem_writer.sv
// Fills the EX3 data memory with DEPTH bytes taken from a valid/ready stream,
// one byte every two cycles, and keeps golden min/sum of what was written.
module ex3_mem_writer
    import ex3_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          go_i,
    output logic          done_o,
    output logic          busy_o,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [DW-1:0] wr_min_o,
    output logic [SW-1:0] wr_sum_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          stat_clr, stat_upd;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        stat_clr = 1'b0;
        stat_upd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    count_d  = '0;
                    stat_clr = 1'b1;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (in_valid_i) begin
                    wdata_d  = in_data_i;
                    addr_d   = count_q;
                    we_d     = 1'b1;
                    stat_upd = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                // count stops at the last address so it never wraps
                if (count_q == LAST_ADDR) begin
                    state_d = FIN;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = RECV;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    ex3_stat_acc #(
        .P_DW (DW),
        .P_SW (SW)
    ) u_stat_acc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (stat_clr),
        .upd_i  (stat_upd),
        .data_i (in_data_i),
        .min_o  (wr_min_o),
        .sum_o  (wr_sum_o)
    );

    assign in_ready_o  = (state_q == RECV);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_ex3_mem_writer.sv
// Directed bench for ex3_mem_writer: expected writes are queued as bytes are
// handed over and matched against each observed mem_we pulse.
module tb_ex3_mem_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        go = 1'b0;
    logic        done, busy, in_ready, mem_we;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, wr_min;
    logic [12:0] wr_sum;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int go_cyc   = 0;
    logic [12:0] exp_q[$];
    logic [12:0] sb_e;

    ex3_mem_writer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .go_i        (go),
        .done_o      (done),
        .busy_o      (busy),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .wr_min_o    (wr_min),
        .wr_sum_o    (wr_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every write must match the oldest handed-over byte.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("we_addr", 32'(mem_addr), 32'(sb_e[12:8]));
                chk("we_data", 32'(mem_wdata), 32'(sb_e[7:0]));
                $display("write addr=%0d data=%0h", mem_addr, mem_wdata);
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_min"}, 32'(wr_min), 0);
        chk({tag, "_sum"}, 32'(wr_sum), 0);
    endtask

    // Hands one byte over; returns one time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input int idx, input int gap,
                             input bit stall_chk, input bit pulse_go);
        int n;
        for (int j = 0; j < gap; j++) begin
            in_valid = 1'b0;
            if (stall_chk && j > 0) chk("ready_in_gap", 32'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        if (pulse_go) go = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            go = 1'b0;
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        go = 1'b0;
        exp_q.push_back({idx[4:0], d});
    endtask

    // mode 0: ascending, 1: all 0xFF, 2: descending from 100, 3: random
    task automatic run(input string name, input int mode, input int gapmax,
                       input int go_at, input int stop_at);
        logic [7:0] data[32];
        logic [7:0] exp_min;
        int exp_sum;
        int n;
        exp_min = 8'hFF;
        exp_sum = 0;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0: data[i] = 8'(i);
                1: data[i] = 8'hFF;
                2: data[i] = 8'(100 - i);
                default: data[i] = 8'($urandom_range(0, 255));
            endcase
            exp_sum += int'(data[i]);
            if (data[i] < exp_min) exp_min = data[i];
        end
        wr_cnt = 0;
        done_cnt = 0;
        exp_q.delete();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        go_cyc = cyc;
        chk({name, "_busy_after_go"}, 32'(busy), 1);
        for (int i = 0; i < 32; i++) begin
            if (i == stop_at) return;
            send_byte(data[i], i, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0,
                      gapmax > 0, i == go_at);
        end
        in_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt), 1);
        if (gapmax == 0) chk({name, "_done_latency"}, 32'(done_cyc - go_cyc), 65);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_once"}, 32'(done_cnt), 1);
        chk({name, "_writes"}, 32'(wr_cnt), 32);
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 0);
        chk({name, "_min"}, 32'(wr_min), 32'(exp_min));
        chk({name, "_sum"}, 32'(wr_sum), 32'(exp_sum));
        chk({name, "_idle"}, 32'(busy), 0);
        $display("run %s: min=%0d sum=%0d done_cnt=%0d writes=%0d",
                 name, wr_min, wr_sum, done_cnt, wr_cnt);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_all_zero("idle");
        end

        run("ascending", 0, 0, -1, -1);
        chk("asc_sum_496", 32'(wr_sum), 496);
        run("all_ff", 1, 0, -1, -1);
        chk("ff_sum_8160", 32'(wr_sum), 8160);
        run("descending", 2, 0, -1, -1);
        chk("desc_min_69", 32'(wr_min), 69);
        chk("desc_sum_2704", 32'(wr_sum), 2704);
        run("stalled", 3, 3, -1, -1);
        run("go_busy", 3, 0, 10, -1);

        run("abort", 0, 0, -1, 5);
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        chk("midrun_sb_empty", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run("after_reset", 0, 0, -1, -1);
        chk("after_reset_sum", 32'(wr_sum), 496);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
